// File: rtl/multicycle_ctrl32_pkg.sv
// Shared constants and the instruction-class type for the 32-bit MIPS-subset
// control path (multi-cycle FSM and the single-cycle decoder).
package ctrl32_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_JR,
    CL_IFMT,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_J,
    CL_JAL,
    CL_ILL
  } instr_class_t;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] REG_RT = 2'b00;
  localparam logic [1:0] REG_RD = 2'b01;
  localparam logic [1:0] REG_RA = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_IFMT  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl32_dec.sv
// Combinational instruction-class decoder, shared by the single-cycle and
// multi-cycle control paths.
module instr_class_dec
  import ctrl32_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  output logic [3:0] instr_class,
  output logic       sftmd
);

  instr_class_t cls;

  always_comb begin
    cls   = CL_ILL;
    sftmd = 1'b0;
    casez (Opcode)
      OP_RTYPE: begin
        if (Function_opcode == FN_JR) begin
          cls = CL_JR;
        end else begin
          cls   = CL_RTYPE;
          sftmd = (Function_opcode[5:3] == 3'b000);
        end
      end
      6'b001???: cls = CL_IFMT;
      OP_LW:     cls = CL_LW;
      OP_SW:     cls = CL_SW;
      OP_BEQ:    cls = CL_BEQ;
      OP_BNE:    cls = CL_BNE;
      OP_J:      cls = CL_J;
      OP_JAL:    cls = CL_JAL;
      default:   cls = CL_ILL;
    endcase
  end

  assign instr_class = cls;

endmodule

// File: rtl/multicycle_ctrl32.sv
// Multi-cycle sequencing controller: steps each instruction through
// IF/ID/EX/MEM/WB, drives the shared memory port and counts retirements.
module multicycle_ctrl32
  import ctrl32_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Function_opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             sftmd,
  output logic             illegal,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  logic [3:0]   cls_bits;
  logic         dec_sftmd;
  instr_class_t cls;
  logic [2:0]   next_state;
  logic         taken;

  instr_class_dec u_dec (
    .Opcode          (Opcode),
    .Function_opcode (Function_opcode),
    .instr_class     (cls_bits),
    .sftmd           (dec_sftmd)
  );

  assign cls   = instr_class_t'(cls_bits);
  assign taken = (cls == CL_BEQ) ? Zero : ~Zero;

  // Outputs are forced quiet while reset is held so nothing reaches the datapath.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    reg_write  = 1'b0;
    reg_dst    = REG_RT;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    sftmd      = 1'b0;
    illegal    = 1'b0;
    if (reset) begin
      case (state)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            next_state = S_ID;
          end
        end
        S_ID: begin
          case (cls)
            CL_J: begin
              pc_write   = 1'b1;
              pc_src     = PC_JUMP;
              next_state = S_IF;
            end
            CL_JR: begin
              pc_write   = 1'b1;
              pc_src     = PC_RS;
              next_state = S_IF;
            end
            CL_JAL: next_state = S_WB;
            CL_ILL: begin
              illegal    = 1'b1;
              pc_write   = 1'b1;
              next_state = S_IF;
            end
            default: next_state = S_EX;
          endcase
        end
        S_EX: begin
          case (cls)
            CL_RTYPE: begin
              alu_op     = ALU_RTYPE;
              sftmd      = dec_sftmd;
              next_state = S_WB;
            end
            CL_IFMT: begin
              alu_op     = ALU_IFMT;
              alu_src    = 1'b1;
              next_state = S_WB;
            end
            CL_LW, CL_SW: begin
              alu_src    = 1'b1;
              next_state = S_MEM;
            end
            CL_BEQ, CL_BNE: begin
              alu_op     = ALU_SUB;
              pc_write   = 1'b1;
              pc_src     = taken ? PC_BRANCH : PC_PLUS4;
              next_state = S_IF;
            end
            default: next_state = S_IF;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls == CL_SW);
          if (mem_ready) begin
            if (cls == CL_SW) begin
              pc_write   = 1'b1;
              next_state = S_IF;
            end else begin
              next_state = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          next_state = S_IF;
          case (cls)
            CL_RTYPE: reg_dst = REG_RD;
            CL_LW:    mem_to_reg = 1'b1;
            CL_JAL: begin
              reg_dst = REG_RA;
              pc_src  = PC_JUMP;
            end
            default: reg_dst = REG_RT;
          endcase
        end
        default: next_state = S_IF;
      endcase
    end
    instr_done = pc_write;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_IF;
      retired <= '0;
    end else begin
      state <= next_state;
      if (instr_done) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/multicycle_ctrl32.md
# multicycle_ctrl32

Multi-cycle sequencing controller for the 32-bit MIPS-subset CPU. It replaces the single-cycle decoder's one-shot control with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives one shared memory port through a req/ready handshake and issues per-cycle enables to the PC, IR, register file and ALU. It sits between the instruction register and the existing datapath blocks and also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- Opcode  in  6  instruction[31:26] from IR; valid from S_ID until the next ir_write
- Function_opcode  in  6  instruction[5:0] from IR; same validity as Opcode
- Zero  in  1  ALU zero flag; sampled in S_EX
- mem_ready  in  1  shared memory completes the current request this cycle
- mem_req  out  1  memory request; held high until mem_ready
- mem_we  out  1  write qualifier for mem_req (SW data access only)
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC this cycle
- pc_src  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 jump target, 11 rs (JR)
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  1  write-back data from memory (LW) instead of ALU/link
- alu_src  out  1  ALU operand B = sign/zero-extended immediate
- alu_op  out  2  00 add, 01 sub (branch compare), 10 R-type funct, 11 I-format op
- sftmd  out  1  shift instruction (R-type, funct[5:3]=000)
- illegal  out  1  one-cycle pulse in S_ID for an unsupported opcode
- instr_done  out  1  one-cycle pulse on the final cycle of every instruction
- retired  out  CNT_W  count of instr_done pulses; wraps modulo 2^CNT_W
- state  out  3  current state encoding, for debug

## Operation
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4.
- Instruction classes are decoded from Opcode/Function_opcode:
  - RTYPE: op 000000, funct ≠ 001000
  - JR: op 000000, funct 001000
  - IFMT: op 001xxx
  - LW: 100011
  - SW: 101011
  - BEQ: 000100
  - BNE: 000101
  - J: 000010
  - JAL: 000011
  - ILL: any other opcode
- S_IF: mem_req=1, mem_we=0. Stay in S_IF while mem_ready=0. When mem_ready=1: ir_write=1, go to S_ID.
- S_ID (one cycle), by class:
  - J: pc_write=1, pc_src=10, done, go to S_IF.
  - JR: pc_write=1, pc_src=11, done, go to S_IF.
  - JAL: go to S_WB.
  - ILL: illegal=1, pc_write=1, pc_src=00, done, go to S_IF. ILL is a NOP.
  - All other classes: go to S_EX.
- S_EX (one cycle), by class:
  - RTYPE: alu_op=10, alu_src=0, go to S_WB.
  - IFMT: alu_op=11, alu_src=1, go to S_WB.
  - LW/SW: alu_op=00, alu_src=1, go to S_MEM.
  - BEQ/BNE: alu_op=01, alu_src=0. Taken = Zero for BEQ, ~Zero for BNE. pc_write=1, pc_src = taken ? 01 : 00. Done, go to S_IF.
- S_MEM: mem_req=1, mem_we = (class==SW). Wait while mem_ready=0. When mem_ready=1:
  - LW: go to S_WB.
  - SW: pc_write=1, pc_src=00, done, go to S_IF.
- S_WB (one cycle): reg_write=1, pc_write=1, done, go to S_IF. pc_src by class:
  - RTYPE: reg_dst=01, pc_src=00.
  - IFMT: reg_dst=00, pc_src=00.
  - LW: reg_dst=00, mem_to_reg=1, pc_src=00.
  - JAL: reg_dst=10, pc_src=10. Link value PC+4 is selected by the datapath when reg_dst=10.
- sftmd is asserted in S_EX for RTYPE with funct[5:3]=000; 0 otherwise.
- instr_done pulses exactly when pc_write=1. retired increments on that same edge.
- Any output not named for the current state/class is 0.

## Timing
- All control outputs are combinational from the registered state and class; no output depends combinationally on mem_ready except ir_write and the S_MEM exit outputs. retired is registered.
- While reset=0 at an edge: state←S_IF and retired←0. All other outputs read 0 while reset is low. The first cycle after release is S_IF with mem_req=1.
- Cycles per instruction with zero-wait memory:
  - J, JR, ILL: 2
  - BEQ, BNE, JAL: 3
  - RTYPE, IFMT, SW: 4
  - LW: 5
  - Each wait cycle (mem_ready=0 in S_IF or S_MEM) adds 1.
- Handshake: mem_req stays high and mem_we stays stable until the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Reset mid-instruction (including during a memory wait) abandons the instruction: no pc_write, no reg_write, no count.
- retired at 2^CNT_W−1 plus one instr_done wraps to 0.

## Structure
- Package ctrl32_pkg holds:
  - the state encoding constants S_IF..S_WB
  - opcode/funct constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, FN_JR
  - the instruction-class enumeration
  - pc_src, reg_dst and alu_op code constants
- One combinational sub-module, instr_class_dec (Opcode, Function_opcode → class, sftmd), is shared with the single-cycle path. The FSM and counter live in multicycle_ctrl32.

## Test plan
- Reset held low 3 cycles with mem_ready=1: all outputs 0, retired=0. After release, state=0 and mem_req=1.
- ADD (op 000000, funct 100000), zero-wait: states IF,ID,EX,WB. alu_op=10 in EX. In WB: reg_write=1, reg_dst=01, pc_write=1, pc_src=00. retired=1.
- LW with mem_ready low for 2 cycles in IF and 3 in S_MEM: 10 cycles total. mem_req continuous in both waits. mem_to_reg=1 in WB.
- BEQ: Zero=1 gives pc_src=01 in EX. Then BNE: Zero=1 gives pc_src=00. Each takes 3 cycles with no reg_write.
- JAL: pc_src=10 and reg_dst=10 with reg_write in WB. JR (funct 001000): pc_src=11 in ID, 2 cycles. Opcode 111111: illegal pulse, 2 cycles, retired increments.
- Reset asserted during an S_MEM wait of an SW: no pc_write or mem_we after the reset edge, retired unchanged from 0. Separately, preload retired near 2^CNT_W−1 and confirm it wraps to 0.
